// File: rtl/zone_stats_pkg.sv
// Shared types and helpers for the per-zone luminance extractor.
// Mode encodings and a width helper used by every file of this block.
package zone_stats_pkg;

  typedef enum logic {
    MODE_MAX  = 1'b0,
    MODE_MEAN = 1'b1
  } mode_e;

  // Bits needed to index `value` items; never returns less than 1.
  function automatic int zs_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/zone_stats_if.sv
// Pixel input and zone-result stream of zone_stats.
// The slave modport is the extractor; the master modport is the source/consumer side.
interface zone_stats_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int IDX_W  = 9
);
  logic              vs;
  logic              hs;
  logic              data_vld;
  logic [DATA_W-1:0] R;
  logic [DATA_W-1:0] G;
  logic [DATA_W-1:0] B;
  logic              i_mode;

  logic              o_valid;
  logic              i_ready;
  logic [OUT_W-1:0]  o_value;
  logic [IDX_W-1:0]  o_index;
  logic              o_frame_last;
  logic              o_overflow;
  logic              o_short_frame;

  modport master (
    output vs, hs, data_vld, R, G, B, i_mode, i_ready,
    input  o_valid, o_value, o_index, o_frame_last, o_overflow, o_short_frame
  );

  modport slave (
    input  vs, hs, data_vld, R, G, B, i_mode, i_ready,
    output o_valid, o_value, o_index, o_frame_last, o_overflow, o_short_frame
  );
endinterface

// File: rtl/zone_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
// A write while full is accepted only if a read frees a slot in the same cycle.
module zone_fifo
  import zone_stats_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = zs_clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage arrays are left out of reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/zone_stats.sv
// Per-zone luminance extractor: reduces each ZONE_W x ZONE_H block of max(R,G,B)
// to a peak or scaled sum and streams the results in raster zone order.
module zone_stats
  import zone_stats_pkg::*;
#(
  parameter int H_ACTIVE   = 1920,
  parameter int V_ACTIVE   = 1080,
  parameter int ZONES_X    = 32,
  parameter int ZONES_Y    = 16,
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 16,
  parameter int SUM_SHIFT  = 8,
  parameter bit VS_POL     = 1'b1,
  parameter int FIFO_DEPTH = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  zone_stats_if.slave bus
);
  localparam int ZONE_W  = H_ACTIVE / ZONES_X;
  localparam int ZONE_H  = V_ACTIVE / ZONES_Y;
  localparam int N_ZONES = ZONES_X * ZONES_Y;
  localparam int SUM_W   = zs_clog2(ZONE_W * ZONE_H * ((1 << DATA_W) - 1) + 1);
  localparam int CW      = (SUM_W > OUT_W) ? SUM_W : OUT_W;
  localparam int IDX_W   = zs_clog2(N_ZONES);
  localparam int PX_W    = zs_clog2(H_ACTIVE + 1);
  localparam int LN_W    = zs_clog2(V_ACTIVE + 1);
  localparam int SG_W    = zs_clog2(ZONE_W);
  localparam int ZX_W    = zs_clog2(ZONES_X);
  localparam int RL_W    = zs_clog2(ZONE_H);
  localparam int ZY_W    = zs_clog2(ZONES_Y);
  localparam int ENT_W   = OUT_W + IDX_W + 1;

  function automatic logic [SUM_W-1:0] merge(input mode_e m, input logic [SUM_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    if (m == MODE_MEAN) return a + b;
    return (a > b) ? a : b;
  endfunction

  // ---------------- input side: sync edges and raster counters ----------------
  logic            vs_d, dv_d, fs_q, seen_vs, short_frame;
  mode_e           mode;
  logic [PX_W-1:0] pix_cnt;
  logic [LN_W-1:0] line_cnt;
  logic [SG_W-1:0] seg_cnt;
  logic [ZX_W-1:0] zx;
  logic [RL_W-1:0] row_line;
  logic [ZY_W-1:0] zy;
  logic            fs_edge, line_end, pixel_in;
  logic [DATA_W-1:0] luma;
  logic            unused_hs;

  assign unused_hs = bus.hs;
  assign fs_edge   = (bus.vs == VS_POL) && (vs_d != VS_POL);
  assign line_end  = dv_d && !bus.data_vld;
  assign pixel_in  = bus.data_vld && (pix_cnt < PX_W'(H_ACTIVE)) && (line_cnt < LN_W'(V_ACTIVE));

  always_comb begin
    // NOTE: every always_comb output gets a value before any branch, so no latch can form.
    luma = bus.R;
    if (bus.G > luma) luma = bus.G;
    if (bus.B > luma) luma = bus.B;
  end

  // The vs edge is acted on one cycle late so a boundary push in the edge cycle still completes.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vs_d        <= VS_POL;
      dv_d        <= 1'b0;
      fs_q        <= 1'b0;
      seen_vs     <= 1'b0;
      short_frame <= 1'b0;
      mode        <= MODE_MAX;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      seg_cnt     <= '0;
      zx          <= '0;
      row_line    <= '0;
      zy          <= '0;
    end else begin
      vs_d        <= bus.vs;
      dv_d        <= bus.data_vld;
      fs_q        <= fs_edge;
      short_frame <= fs_q && seen_vs && (line_cnt < LN_W'(V_ACTIVE));
      if (fs_q) begin
        seen_vs  <= 1'b1;
        mode     <= mode_e'(bus.i_mode);
        pix_cnt  <= '0;
        line_cnt <= '0;
        seg_cnt  <= '0;
        zx       <= '0;
        row_line <= '0;
        zy       <= '0;
      end else if (line_end) begin
        pix_cnt <= '0;
        seg_cnt <= '0;
        zx      <= '0;
        if ((pix_cnt != '0) && (line_cnt < LN_W'(V_ACTIVE))) begin
          line_cnt <= line_cnt + 1'b1;
          if (row_line == RL_W'(ZONE_H - 1)) begin
            row_line <= '0;
            zy       <= zy + 1'b1;
          end else begin
            row_line <= row_line + 1'b1;
          end
        end
      end else if (bus.data_vld && (pix_cnt < PX_W'(H_ACTIVE))) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (seg_cnt == SG_W'(ZONE_W - 1)) begin
          seg_cnt <= '0;
          zx      <= zx + 1'b1;
        end else begin
          seg_cnt <= seg_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- stage 1: registered luma and zone position ----------------
  logic              l_vld, l_clr, l_bnd, l_first, l_last;
  logic [DATA_W-1:0] l_luma;
  logic [ZX_W-1:0]   l_zx;
  logic [IDX_W-1:0]  l_idx;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      l_vld   <= 1'b0;
      l_clr   <= 1'b0;
      l_bnd   <= 1'b0;
      l_first <= 1'b0;
      l_last  <= 1'b0;
      l_luma  <= '0;
      l_zx    <= '0;
      l_idx   <= '0;
    end else begin
      l_vld   <= pixel_in && !fs_q;
      l_clr   <= line_end || fs_q;
      l_bnd   <= (seg_cnt == SG_W'(ZONE_W - 1));
      l_first <= (row_line == '0);
      l_last  <= (row_line == RL_W'(ZONE_H - 1));
      l_luma  <= luma;
      l_zx    <= zx;
      l_idx   <= IDX_W'(int'(zy) * ZONES_X + int'(zx));
    end
  end

  // ---------------- stage 2: segment merge, column accumulators, push ----------------
  logic [SUM_W-1:0] cur;
  logic [SUM_W-1:0] acc [ZONES_X];
  logic [SUM_W-1:0] seg_c, merged_c;
  logic [CW-1:0]    wide;
  logic [OUT_W-1:0] zone_value;
  logic             push_vld;
  logic [ENT_W-1:0] push_data;

  always_comb begin
    seg_c    = merge(mode, cur, SUM_W'(l_luma));
    merged_c = l_first ? seg_c : merge(mode, acc[l_zx], seg_c);
    wide     = (mode == MODE_MEAN) ? CW'(merged_c >> SUM_SHIFT) : CW'(merged_c);
    zone_value = ((wide >> OUT_W) != '0) ? '1 : wide[OUT_W-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cur       <= '0;
      push_vld  <= 1'b0;
      push_data <= '0;
    end else begin
      push_vld <= 1'b0;
      if (l_clr) begin
        cur <= '0;
      end else if (l_vld) begin
        if (l_bnd) begin
          cur <= '0;
          if (l_last) begin
            push_vld  <= 1'b1;
            push_data <= {(l_idx == IDX_W'(N_ZONES - 1)), l_idx, zone_value};
          end
        end else begin
          cur <= seg_c;
        end
      end
    end
  end

  // The first line of each zone row overwrites its column, so stale data never leaks.
  always_ff @(posedge sys_clk) begin
    if (!l_clr && l_vld && l_bnd && !l_last) acc[l_zx] <= merged_c;
  end

  // ---------------- output FIFO ----------------
  logic             fifo_full, fifo_empty, pop, drop, overflow;
  logic [ENT_W-1:0] rd_data;

  assign pop  = !fifo_empty && bus.i_ready;
  assign drop = push_vld && fifo_full && !pop;

  zone_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .wr_en   (push_vld),
    .wr_data (push_data),
    .rd_en   (bus.i_ready),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst)   overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
    else if (fs_q)  overflow <= 1'b0;
  end

  // Payload is forced to zero while empty so reset and idle present all-zero outputs.
  assign bus.o_valid = !fifo_empty;
  assign {bus.o_frame_last, bus.o_index, bus.o_value} = fifo_empty ? '0 : rd_data;
  assign bus.o_overflow    = overflow;
  assign bus.o_short_frame = short_frame;

endmodule

// File: tb/tb_zone_stats.sv
// Self-checking bench for zone_stats on a 16x8 frame split into 4x2 zones of 4x4 pixels.
// Frame vectors come from a table; a scoreboard queue holds the expected zone stream.
module tb_zone_stats;
  import zone_stats_pkg::*;

  localparam int H = 16, V = 8, ZX = 4, ZY = 2, NZ = ZX * ZY, IDX_W = 3;
  localparam int ZW = H / ZX, ZH = V / ZY;

  typedef struct packed {
    logic [15:0]      value;
    logic [IDX_W-1:0] index;
    logic             last;
  } exp_t;

  typedef struct {
    string name;
    bit    mode;
    int    base_ch;
    int    base;
    int    hot_x, hot_y, hot;
    int    line_len, n_lines;
    int    exp_base, hot_zone, hot_val;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   short_cnt = 0;
  int   lat_cyc = 0;
  int   zone0_cyc = 0;
  bit   lat_arm = 1'b0;
  exp_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zone_stats_if #(.DATA_W(8), .OUT_W(16), .IDX_W(IDX_W)) bus ();

  zone_stats #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ZONES_X(ZX), .ZONES_Y(ZY), .DATA_W(8), .OUT_W(16),
    .SUM_SHIFT(4), .VS_POL(1'b1), .FIFO_DEPTH(4)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst_n),
    .bus     (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input bit mode, input int ch, input int base,
                              input int hx, input int hy, input int hot, input int ll,
                              input int nl, input int eb, input int hz, input int hv);
    vec_t v;
    v.name = name; v.mode = mode; v.base_ch = ch; v.base = base;
    v.hot_x = hx; v.hot_y = hy; v.hot = hot; v.line_len = ll; v.n_lines = nl;
    v.exp_base = eb; v.hot_zone = hz; v.hot_val = hv;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input bit mode);
    bus.i_mode = mode;
    bus.vs = 1'b1;
    tick(); tick();
    bus.vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic push_exp(input vec_t v, input int z_lo, input int z_hi);
    for (int z = z_lo; z <= z_hi; z++) begin
      exp_t e;
      e.value = 16'((z == v.hot_zone) ? v.hot_val : v.exp_base);
      e.index = IDX_W'(z);
      e.last  = (z == NZ - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_lines(input vec_t v, input int n_lines);
    for (int y = 0; y < n_lines; y++) begin
      for (int x = 0; x < v.line_len; x++) begin
        if (x >= H || y >= V) begin
          bus.R = 8'd255; bus.G = 8'd255; bus.B = 8'd255;
        end else begin
          bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
          case (v.base_ch)
            0:       bus.R = 8'(v.base);
            1:       bus.G = 8'(v.base);
            default: bus.B = 8'(v.base);
          endcase
          if (x == v.hot_x && y == v.hot_y) bus.R = 8'(v.hot);
        end
        bus.data_vld = 1'b1;
        if (x == ZW - 1 && y == ZH - 1) zone0_cyc = cyc;
        tick();
      end
      bus.data_vld = 1'b0;
      bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
      repeat (3) tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    repeat (4) tick();
  endtask

  // Scoreboard side: every accepted transfer is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_short_frame) short_cnt++;
      if (lat_arm && bus.o_valid) begin
        lat_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (bus.o_valid && bus.i_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_zone: got index %0d value %0d, expected no output",
                   bus.o_index, bus.o_value);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("zone_value", int'(bus.o_value), int'(e.value));
          check("zone_index", int'(bus.o_index), int'(e.index));
          check("zone_frame_last", int'(bus.o_frame_last), int'(e.last));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    vecs[0] = mk("max_hot",        1'b0, 1,  10,  5, 2, 200, 16,  8,  10,  1, 200);
    vecs[1] = mk("mean_g16",       1'b1, 1,  16, -1, -1,  0, 16,  8,  16, -1,   0);
    vecs[2] = mk("mean_255",       1'b1, 2, 255, -1, -1,  0, 16,  8, 255, -1,   0);
    vecs[3] = mk("max_long_lines", 1'b0, 2,  10, -1, -1,  0, 20,  8,  10, -1,   0);
    vecs[4] = mk("mean_hot_extra", 1'b1, 0,  10, 14, 6, 200, 16, 12,  10,  7,  21);
    vecs[5] = mk("max_edge_pixel", 1'b0, 0,   5,  3, 7,  77, 16,  8,   5,  4,  77);

    bus.vs = 1'b0; bus.hs = 1'b0; bus.data_vld = 1'b0; bus.i_mode = 1'b0;
    bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0; bus.i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_valid", bus.o_valid, 0);
    check("reset_o_value", bus.o_value, 0);
    check("reset_o_index", bus.o_index, 0);
    check("reset_o_frame_last", bus.o_frame_last, 0);
    check("reset_o_overflow", bus.o_overflow, 0);
    check("reset_o_short_frame", bus.o_short_frame, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 6; i++) begin
      frame_start(vecs[i].mode);
      if (i == 0) lat_arm = 1'b1;
      push_exp(vecs[i], 0, NZ - 1);
      drive_lines(vecs[i], vecs[i].n_lines);
      wait_drain(vecs[i].name);
      if (i == 0) check("first_zone_latency", lat_cyc - zone0_cyc, 3);
    end
    check("no_short_on_full_frames", short_cnt, 0);

    // Stalled consumer: only the first four zones fit, the rest are dropped.
    frame_start(1'b0);
    bus.i_ready = 1'b0;
    push_exp(vecs[0], 0, 3);
    drive_lines(vecs[0], V);
    repeat (5) tick();
    check("ovf_set", bus.o_overflow, 1);
    check("ovf_hold_valid", bus.o_valid, 1);
    check("ovf_hold_index", bus.o_index, 0);
    check("ovf_hold_value", bus.o_value, 10);
    frame_start(1'b0);
    check("ovf_cleared_by_vs", bus.o_overflow, 0);
    check("ovf_entries_kept", bus.o_valid, 1);
    bus.i_ready = 1'b1;
    wait_drain("ovf_drain");

    // Short frame: only zone row 0 completes before the next vs.
    frame_start(1'b1);
    push_exp(vecs[1], 0, ZX - 1);
    drive_lines(vecs[1], 5);
    wait_drain("short_row0");
    s0 = short_cnt;
    frame_start(1'b0);
    check("short_pulse_once", short_cnt - s0, 1);
    push_exp(vecs[0], 0, NZ - 1);
    drive_lines(vecs[0], V);
    wait_drain("after_short");
    s0 = short_cnt;
    frame_start(1'b0);
    check("no_short_after_full", short_cnt - s0, 0);

    // Reset while results are waiting.
    bus.i_ready = 1'b0;
    drive_lines(vecs[0], ZH);
    repeat (4) tick();
    check("pre_reset_valid", bus.o_valid, 1);
    check("pre_reset_value", bus.o_value, 10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_value", bus.o_value, 0);
    check("rst_o_index", bus.o_index, 0);
    check("rst_o_frame_last", bus.o_frame_last, 0);
    check("rst_o_overflow", bus.o_overflow, 0);
    check("rst_o_short_frame", bus.o_short_frame, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    s0 = short_cnt;
    frame_start(1'b0);
    check("no_short_after_reset", short_cnt - s0, 0);
    push_exp(vecs[0], 0, NZ - 1);
    drive_lines(vecs[0], V);
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
